// File: rtl/cpu5_pkg.sv
// Shared definitions for the 5-bit CPU slice.
//   DATA_W    : instruction word width
//   ADDR_W    : program RAM address width
//   RAM_DEPTH : program RAM entries
//   loader_state_t : program_loader FSM states
package cpu5_pkg;

  localparam int DATA_W    = 11;
  localparam int ADDR_W    = 3;
  localparam int RAM_DEPTH = 8;

  typedef enum logic [1:0] {
    LD_IDLE,
    LD_LOAD,
    LD_FILL,
    LD_RUN
  } loader_state_t;

endpackage

// File: rtl/program_loader.sv
// program_loader: streams instruction words into the CPU program RAM in
// order, optionally zero-fills the unused tail, then enables the PC.
//
// Ports
//   clk, reset          : clock, synchronous active-high reset
//   load_start          : one-cycle load request (IDLE or RUN only)
//   halt                : in RUN, stop the CPU and return to IDLE
//   in_valid/in_ready   : word stream handshake
//   in_data, in_last    : instruction word, final-word marker
//   RAM_Write_*         : CPU program RAM write port (registered)
//   PC_Enable           : CPU run enable
//   busy                : loading or filling
//   word_count          : words accepted in the current load (0..8)
//   overrun             : sticky, last RAM entry taken without in_last
module program_loader #(
  parameter int DATA_W    = cpu5_pkg::DATA_W,
  parameter int ADDR_W    = cpu5_pkg::ADDR_W,
  parameter bit ZERO_FILL = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic              halt,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              RAM_Write_Enable,
  output logic [ADDR_W-1:0] RAM_Write_Address,
  output logic [DATA_W-1:0] RAM_Write_Data,
  output logic              PC_Enable,
  output logic              busy,
  output logic [ADDR_W:0]   word_count,
  output logic              overrun
);

  import cpu5_pkg::loader_state_t;
  import cpu5_pkg::LD_IDLE;
  import cpu5_pkg::LD_LOAD;
  import cpu5_pkg::LD_FILL;
  import cpu5_pkg::LD_RUN;

  localparam logic [ADDR_W:0] COUNT_MAX = {1'b1, {ADDR_W{1'b0}}};

  loader_state_t     state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              wr_en_d;
  logic [ADDR_W-1:0] wr_addr_d;
  logic [DATA_W-1:0] wr_data_d;
  logic [ADDR_W:0]   count_d;
  logic              overrun_d;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    wr_en_d   = 1'b0;
    wr_addr_d = RAM_Write_Address;
    wr_data_d = RAM_Write_Data;
    count_d   = word_count;
    overrun_d = overrun;

    unique case (state_q)
      LD_IDLE: begin
        if (load_start) begin
          state_d   = LD_LOAD;
          ptr_d     = '0;
          count_d   = '0;
          overrun_d = 1'b0;
        end
      end

      LD_LOAD: begin
        // in_ready is always high while in LOAD, so in_valid is the handshake
        if (in_valid) begin
          wr_en_d   = 1'b1;
          wr_addr_d = ptr_q;
          wr_data_d = in_data;
          ptr_d     = ptr_q + 1'b1;
          if (word_count != COUNT_MAX) count_d = word_count + 1'b1;
          if (in_last || (ptr_q == '1)) begin
            if (!in_last) overrun_d = 1'b1;
            // a word landing at the top address wraps the pointer: nothing to fill
            state_d = (ZERO_FILL && (ptr_q != '1)) ? LD_FILL : LD_RUN;
          end
        end
      end

      LD_FILL: begin
        wr_en_d   = 1'b1;
        wr_addr_d = ptr_q;
        wr_data_d = '0;
        if (ptr_q == '1) state_d = LD_RUN;
        else             ptr_d   = ptr_q + 1'b1;
      end

      LD_RUN: begin
        // a reload takes priority over halt
        if (load_start) begin
          state_d   = LD_LOAD;
          ptr_d     = '0;
          count_d   = '0;
          overrun_d = 1'b0;
        end else if (halt) begin
          state_d = LD_IDLE;
        end
      end

      default: state_d = LD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q           <= LD_IDLE;
      ptr_q             <= '0;
      in_ready          <= 1'b0;
      RAM_Write_Enable  <= 1'b0;
      RAM_Write_Address <= '0;
      RAM_Write_Data    <= '0;
      PC_Enable         <= 1'b0;
      busy              <= 1'b0;
      word_count        <= '0;
      overrun           <= 1'b0;
    end else begin
      state_q           <= state_d;
      ptr_q             <= ptr_d;
      in_ready          <= (state_d == LD_LOAD);
      RAM_Write_Enable  <= wr_en_d;
      RAM_Write_Address <= wr_addr_d;
      RAM_Write_Data    <= wr_data_d;
      // enabling only after a full cycle in RUN keeps PC_Enable one cycle
      // behind the final RAM write
      PC_Enable         <= (state_q == LD_RUN) && (state_d == LD_RUN);
      busy              <= (state_d == LD_LOAD) || (state_d == LD_FILL);
      word_count        <= count_d;
      overrun           <= overrun_d;
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader. Two instances (with and without
// zero-fill) share the same stimulus; a transaction-level model predicts
// each write (address, data, cycle) and the PC_Enable rise cycle.
module tb_program_loader;

  localparam int DW    = cpu5_pkg::DATA_W;
  localparam int AW    = cpu5_pkg::ADDR_W;
  localparam int DEPTH = cpu5_pkg::RAM_DEPTH;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, load_start, halt, in_valid, in_last;
  logic [DW-1:0] in_data;

  logic          rdy_f, we_f, pc_f, busy_f, ovr_f;
  logic [AW-1:0] addr_f;
  logic [DW-1:0] data_f;
  logic [AW:0]   wc_f;
  logic          rdy_n, we_n, pc_n, busy_n, ovr_n;
  logic [AW-1:0] addr_n;
  logic [DW-1:0] data_n;
  logic [AW:0]   wc_n;

  program_loader #(.DATA_W(DW), .ADDR_W(AW), .ZERO_FILL(1'b1)) dut_f (
    .clk(clk), .reset(reset), .load_start(load_start), .halt(halt),
    .in_valid(in_valid), .in_ready(rdy_f), .in_data(in_data), .in_last(in_last),
    .RAM_Write_Enable(we_f), .RAM_Write_Address(addr_f), .RAM_Write_Data(data_f),
    .PC_Enable(pc_f), .busy(busy_f), .word_count(wc_f), .overrun(ovr_f)
  );

  program_loader #(.DATA_W(DW), .ADDR_W(AW), .ZERO_FILL(1'b0)) dut_n (
    .clk(clk), .reset(reset), .load_start(load_start), .halt(halt),
    .in_valid(in_valid), .in_ready(rdy_n), .in_data(in_data), .in_last(in_last),
    .RAM_Write_Enable(we_n), .RAM_Write_Address(addr_n), .RAM_Write_Data(data_n),
    .PC_Enable(pc_n), .busy(busy_n), .word_count(wc_n), .overrun(ovr_n)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int overlap = 0;
  int pr_f = -1, pr_n = -1;
  logic pcf_prev = 1'b0, pcn_prev = 1'b0;
  logic [63:0] wf[$], wn[$];

  function automatic logic [63:0] pack(input int c, input int a, input int d);
    return (64'(c) << 16) | (64'(a & 7) << 11) | 64'(d & 'h7FF);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // write/PC monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (we_f) wf.push_back(pack(cyc, int'(addr_f), int'(data_f)));
    if (we_n) wn.push_back(pack(cyc, int'(addr_n), int'(data_n)));
    if (pc_f && !pcf_prev && pr_f < 0) pr_f = cyc;
    if (pc_n && !pcn_prev && pr_n < 0) pr_n = cyc;
    if ((we_f && pc_f) || (we_n && pc_n)) overlap++;
    pcf_prev = pc_f;
    pcn_prev = pc_n;
  end

  int c0;

  // One complete load. len > DEPTH means no in_last (overrun).
  task automatic run_load(input int len, input int gap_pct, input bit with_halt,
                          input bit plan, input bit noisy);
    logic [DW-1:0] words[DEPTH+1];
    int hs_q[$];
    logic [63:0] exp_n[$], exp_f[$];
    int n_acc, k, budget, w, n_got, last;
    for (int i = 0; i <= DEPTH; i++) words[i] = DW'($urandom);
    if (plan) begin
      words[0] = 11'h603; words[1] = 11'h400; words[2] = 11'h5F0;
    end
    n_acc = (len > DEPTH) ? DEPTH : len;
    wf.delete(); wn.delete();
    pr_f = -1; pr_n = -1;

    c0 = cyc;
    load_start = 1'b1; halt = with_halt;
    tick();
    load_start = 1'b0; halt = 1'b0;
    check("start_ready_f", rdy_f, 1); check("start_ready_n", rdy_n, 1);
    check("start_pc_f", pc_f, 0);     check("start_pc_n", pc_n, 0);
    check("start_busy_f", busy_f, 1); check("start_wc_f", wc_f, 0);
    check("start_ovr_f", ovr_f, 0);   check("start_ovr_n", ovr_n, 0);

    k = 0; budget = 0;
    while (k < n_acc && budget < 300) begin
      in_valid = ($urandom_range(0, 99) >= gap_pct);
      in_data  = words[k];
      in_last  = (k == len - 1);
      if (noisy) begin
        load_start = ($urandom_range(0, 9) == 0);
        halt       = ($urandom_range(0, 9) == 0);
      end
      @(negedge clk);
      if (in_valid && rdy_f) begin
        hs_q.push_back(cyc);
        k++;
      end
      tick();
      budget++;
    end
    in_valid = 1'b0; in_last = 1'b0; load_start = 1'b0; halt = 1'b0;
    check("load_accepted", k, n_acc);
    check("end_ready_f", rdy_f, 0); check("end_ready_n", rdy_n, 0);

    if (len > DEPTH) begin
      in_valid = 1'b1; in_data = words[DEPTH];
      repeat (3) tick();
      in_valid = 1'b0;
    end

    w = 0;
    while (!(pc_f && pc_n) && w < 30) begin
      tick();
      w++;
    end
    check("pc_wait_bounded", (w < 30), 1);
    tick();

    n_got = hs_q.size();
    for (int i = 0; i < n_got; i++) exp_n.push_back(pack(hs_q[i] + 1, i, int'(words[i])));
    exp_f = exp_n;
    last = (n_got > 0) ? hs_q[n_got - 1] + 1 : c0;
    for (int a = n_got; a < DEPTH; a++) exp_f.push_back(pack(last + (a - n_got + 1), a, 0));

    check("nwrites_n", wn.size(), exp_n.size());
    check("nwrites_f", wf.size(), exp_f.size());
    for (int i = 0; i < exp_n.size() && i < wn.size(); i++)
      check($sformatf("wr_n%0d", i), wn[i], exp_n[i]);
    for (int i = 0; i < exp_f.size() && i < wf.size(); i++)
      check($sformatf("wr_f%0d", i), wf[i], exp_f[i]);
    if (exp_n.size() > 0) check("pc_rise_n", pr_n, (exp_n[$] >> 16) + 1);
    if (exp_f.size() > 0) check("pc_rise_f", pr_f, (exp_f[$] >> 16) + 1);
    check("wc_f", wc_f, n_acc); check("wc_n", wc_n, n_acc);
    check("ovr_f", ovr_f, (len > DEPTH)); check("ovr_n", ovr_n, (len > DEPTH));
    check("busy_f", busy_f, 0); check("busy_n", busy_n, 0);
  endtask

  // From RUN: halt, then show in_valid in IDLE is never written.
  task automatic halt_to_idle();
    halt = 1'b1;
    tick();
    halt = 1'b0;
    check("halt_pc_f", pc_f, 0); check("halt_pc_n", pc_n, 0);
    check("halt_ready_f", rdy_f, 0); check("halt_busy_n", busy_n, 0);
    wf.delete(); wn.delete();
    in_valid = 1'b1; in_last = 1'b1; in_data = DW'($urandom);
    repeat (3) tick();
    in_valid = 1'b0; in_last = 1'b0;
    tick();
    check("idle_writes_f", wf.size(), 0); check("idle_writes_n", wn.size(), 0);
  endtask

  task automatic reset_mid_load();
    wf.delete(); wn.delete();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = DW'(11'h100 + i); in_last = 1'b0;
      tick();
    end
    reset = 1'b1; in_data = 11'h102;
    tick();
    check("rst_ready_f", rdy_f, 0); check("rst_ready_n", rdy_n, 0);
    check("rst_we_f", we_f, 0);     check("rst_we_n", we_n, 0);
    check("rst_addr_f", addr_f, 0); check("rst_data_f", data_f, 0);
    check("rst_pc_f", pc_f, 0);     check("rst_busy_f", busy_f, 0);
    check("rst_wc_f", wc_f, 0);     check("rst_wc_n", wc_n, 0);
    check("rst_ovr_f", ovr_f, 0);
    reset = 1'b0; in_last = 1'b1; in_data = 11'h103;
    repeat (3) tick();
    in_valid = 1'b0; in_last = 1'b0;
    tick();
    check("rst_nwrites_f", wf.size(), 2); check("rst_nwrites_n", wn.size(), 2);
    check("rst_idle_busy", busy_f, 0);
  endtask

  initial begin
    reset = 1'b1; load_start = 1'b0; halt = 1'b0;
    in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    repeat (3) tick();
    check("reset_ready", rdy_f, 0); check("reset_we", we_f, 0);
    check("reset_pc", pc_f, 0);     check("reset_busy", busy_n, 0);
    check("reset_wc", wc_n, 0);     check("reset_ovr", ovr_f, 0);
    check("reset_addr", addr_n, 0); check("reset_data", data_n, 0);
    reset = 1'b0;
    tick();

    // three-word program; fill instance runs from cycle 10, plain from 5
    run_load(3, 0, 1'b0, 1'b1, 1'b0);
    check("plan_pc_f_cycle", pr_f, c0 + 10);
    check("plan_pc_n_cycle", pr_n, c0 + 5);
    halt_to_idle();

    // eight words, no in_last: forced end, 9th word refused
    run_load(9, 0, 1'b0, 1'b0, 1'b0);
    halt_to_idle();

    // toggling in_valid
    run_load(5, 50, 1'b0, 1'b0, 1'b0);

    // halt and load_start together in RUN: reload wins
    run_load(2, 0, 1'b1, 1'b0, 1'b0);

    reset_mid_load();

    for (int it = 0; it < 40; it++) begin
      run_load($urandom_range(1, DEPTH + 2), $urandom_range(0, 60),
               1'($urandom_range(0, 1)), 1'b0, 1'b1);
      if ($urandom_range(0, 2) == 0) halt_to_idle();
    end

    check("pc_we_overlap", overlap, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/program_loader.md
# program_loader

Upstream loading stage for the 5-bit CPU. Accepts a valid/ready stream of 11-bit instruction words and writes them in order into the CPU's 8-entry program RAM through its write port (`RAM_Write_Enable` / `RAM_Write_Address` / `RAM_Write_Data`). Optionally zero-fills the unused entries, then asserts `PC_Enable` to start execution. Replaces hand-sequenced RAM writes with a single `load_start` pulse.

## Interface
- `DATA_W`, 11: instruction word width.
- `ADDR_W`, 3: RAM address width; depth = 2**ADDR_W = 8.
- `ZERO_FILL`, 1: when 1, entries after the last loaded word are written with 0 before run.
- `clk`  in  1  clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `load_start`  in  1  single-cycle request to begin a load; honoured in IDLE and RUN.
- `halt`  in  1  in RUN: drop `PC_Enable` and return to IDLE.
- `in_valid`  in  1  stream word valid.
- `in_ready`  out  1  loader can accept a word.
- `in_data`  in  DATA_W  instruction word.
- `in_last`  in  1  marks the final word of the program.
- `RAM_Write_Enable`  out  1  CPU RAM write strobe.
- `RAM_Write_Address`  out  ADDR_W  CPU RAM write address.
- `RAM_Write_Data`  out  DATA_W  CPU RAM write data.
- `PC_Enable`  out  1  CPU run enable.
- `busy`  out  1  high in LOAD or FILL.
- `word_count`  out  ADDR_W+1  words accepted in the current load, 0..8.
- `overrun`  out  1  sticky; the 8th word was accepted without `in_last`.

## Operation
- States: IDLE, LOAD, FILL, RUN.
- IDLE: `load_start` moves to LOAD and clears `word_count`, `overrun`, and the address pointer.
- LOAD: `in_ready` = 1. On handshake (`in_valid && in_ready`), the word is written at the pointer and the pointer increments.
- LOAD exit: the load ends when the accepted word has `in_last`, or when it lands at address 7 (forced end).
  - Forced end without `in_last` sets `overrun`.
  - Next state is FILL if `ZERO_FILL` = 1 and the pointer has not wrapped; otherwise RUN.
- FILL: writes 0 to each remaining address up to 7, one per cycle, then goes to RUN.
- RUN: `PC_Enable` = 1.
  - `halt` goes to IDLE.
  - `load_start` goes to LOAD and wins over a simultaneous `halt`.
- `load_start` in LOAD or FILL is ignored.
- `in_valid` outside LOAD is ignored and never written.
- The pointer is ADDR_W bits and wraps after address 7. The wrap is the exit condition; no write ever occurs at a wrapped address.
- `word_count` saturates at 8.

## Timing
- All outputs are registered. Reset value of every output is 0, state = IDLE.
- Reset mid-load or mid-fill aborts immediately; no further writes occur.
- The RAM write occurs in the cycle after the handshake (1-cycle latency), with a one-cycle `RAM_Write_Enable` pulse. Throughput is 1 word/cycle.
- `load_start` at cycle N gives `in_ready` = 1 at N+1.
- `PC_Enable` rises in the cycle after the final RAM write (load or fill). It is never high in the same cycle as `RAM_Write_Enable`.
- `PC_Enable` falls in the cycle after `halt` or `load_start` is sampled in RUN.
- `in_ready` drops in the cycle after the terminating handshake.

## Structure
- Shared package `cpu5_pkg`:
  - constants `DATA_W` = 11, `ADDR_W` = 3, `RAM_DEPTH` = 8;
  - loader state type (IDLE/LOAD/FILL/RUN).
- Single module with no sub-modules. The address pointer, counter and FSM are inline.

## Test plan
- `ZERO_FILL` = 1; `load_start` at cycle 0; words 0x603, 0x400, 0x5F0 accepted at cycles 1-3, `in_last` on the third.
  - Writes to addresses 0,1,2 at cycles 2-4; zero writes to addresses 3-7 at cycles 5-9.
  - `PC_Enable` = 1 from cycle 10; `word_count` = 3; `overrun` = 0.
- Same stimulus with `ZERO_FILL` = 0: no fill writes; `PC_Enable` = 1 from cycle 5.
- 8 words with no `in_last`:
  - writes to addresses 0-7; `overrun` = 1; `word_count` = 8;
  - `in_ready` = 0 after the 8th word; a 9th `in_valid` is never written.
- `in_valid` toggling 1/0 during LOAD: only handshaken words are written, addresses contiguous with no gaps; `in_valid` in IDLE produces no writes.
- `reset` asserted after 2 of 4 words: next cycle all outputs 0, state IDLE, no further writes.
- In RUN, `halt` and `load_start` in the same cycle: `PC_Enable` drops next cycle, `in_ready` = 1, a new load starts at address 0.
